reg_bank_poci: RTL and testbench

Downstream stage of the PICO deserialiser. It holds the chip's digital configuration register bank and applies the parallel writes that PICO produces. It also serialises the register selected by the PICO address pointer back to the SPI master on the POCI line, MSB first, one bit per sclk. Register contents drive the analog/config fabric through a flat output bus.

---
 rtl/poci_pkg.sv | 32 +++
 rtl/poci_shifter.sv | 68 ++++++
 rtl/reg_bank_poci.sv | 109 ++++++++++
 tb/tb_reg_bank_poci.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/poci_pkg.sv
// poci_pkg: shared definitions for the configuration register bank and its POCI readout.
//   DATA_W          register / shift width
//   CHIP_ID_DEFAULT read-only identifier returned at address 0
//   poci_state_e    readout shifter states
//   rv()            read-value mux: chip id, bank register, or zero for unmapped addresses
package poci_pkg;

   localparam int unsigned DATA_W = 8;
   localparam logic [DATA_W-1:0] CHIP_ID_DEFAULT = 8'hA5;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } poci_state_e;

   // bank_val must already hold reg[addr] when addr is a writable address.
   function automatic logic [DATA_W-1:0] rv(input logic [7:0]        addr,
                                            input int unsigned       num_regs,
                                            input logic [DATA_W-1:0] chip_id,
                                            input logic [DATA_W-1:0] bank_val);
      logic [DATA_W-1:0] val;
      if (addr == 8'd0) begin
         val = chip_id;
      end else if (32'(addr) <= num_regs) begin
         val = bank_val;
      end else begin
         val = '0;
      end
      return val;
   endfunction

endpackage

// File: rtl/poci_shifter.sv
// poci_shifter: serialises one byte MSB first on poci, one bit per sclk.
//   sclk       in   SPI clock, all state changes on posedge
//   rstn       in   asynchronous active-low reset
//   byte_done  in   load request; reloads even in the middle of a byte
//   load_val   in   byte to serialise, sampled with byte_done
//   poci       out  serial bit, driven straight from the shift register MSB
module poci_shifter
   import poci_pkg::*;
(
   input  logic              sclk,
   input  logic              rstn,
   input  logic              byte_done,
   input  logic [DATA_W-1:0] load_val,
   output logic              poci
);

   poci_state_e       state_d, state_q;
   logic [2:0]        cnt_d, cnt_q;
   logic [DATA_W-1:0] shreg_d, shreg_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      unique case (state_q)
         StIdle: begin
            shreg_d = '0;
            if (byte_done) begin
               shreg_d = load_val;
               cnt_d   = 3'd0;
               state_d = StShift;
            end
         end
         StShift: begin
            if (byte_done) begin
               // Restart: a mid-byte pulse truncates whatever is in flight.
               shreg_d = load_val;
               cnt_d   = 3'd0;
            end else if (cnt_q != 3'd7) begin
               shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
               cnt_d   = cnt_q + 3'd1;
            end else begin
               shreg_d = '0;
               state_d = StIdle;
            end
         end
         default: begin
            shreg_d = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
      end
   end

   assign poci = shreg_q[DATA_W-1];

endmodule

// File: rtl/reg_bank_poci.sv
// reg_bank_poci: configuration register bank written by PICO, read back serially on POCI.
//   sclk       in   SPI clock
//   rstn       in   asynchronous active-low chip reset; registers persist across transactions
//   wr_valid   in   one-cycle write request, qualifies wr_addr / wr_data
//   wr_addr    in   write address, writable registers at 1..NUM_REGS
//   wr_data    in   write value
//   byte_done  in   pulse completing an incoming byte; starts a readout byte
//   rd_addr    in   register to read out
//   poci       out  serial readout, MSB first
//   reg_out    out  flat register contents, reg N at [8N-1 -: 8]
//   wr_strobe  out  pulse one cycle after an accepted write
//   addr_err   out  sticky flag for a write above NUM_REGS
module reg_bank_poci
   import poci_pkg::*;
#(
   parameter int unsigned       NUM_REGS = 16,
   parameter logic [DATA_W-1:0] RST_VAL  = 8'h00,
   parameter logic [DATA_W-1:0] CHIP_ID  = CHIP_ID_DEFAULT
) (
   input  logic                       sclk,
   input  logic                       rstn,
   input  logic                       wr_valid,
   input  logic [7:0]                 wr_addr,
   input  logic [DATA_W-1:0]          wr_data,
   input  logic                       byte_done,
   input  logic [7:0]                 rd_addr,
   output logic                       poci,
   output logic [NUM_REGS*DATA_W-1:0] reg_out,
   output logic                       wr_strobe,
   output logic                       addr_err
);

   // regs_q[i] holds register address i+1.
   logic [DATA_W-1:0] regs_d [NUM_REGS];
   logic [DATA_W-1:0] regs_q [NUM_REGS];
   logic              wr_strobe_d, wr_strobe_q;
   logic              addr_err_d, addr_err_q;
   logic              wr_hit, wr_over;
   logic [DATA_W-1:0] bank_val;
   logic [DATA_W-1:0] load_val;

   assign wr_hit  = wr_valid && (wr_addr != 8'd0) && (32'(wr_addr) <= NUM_REGS);
   assign wr_over = wr_valid && (32'(wr_addr) > NUM_REGS);

   always_comb begin
      wr_strobe_d = wr_hit;
      addr_err_d  = addr_err_q | wr_over;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_d[i] = regs_q[i];
         if (wr_hit && (wr_addr == 8'(i + 1))) begin
            regs_d[i] = wr_data;
         end
      end
   end

   // Register selected for readout; only meaningful when rd_addr is writable.
   always_comb begin
      bank_val = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_addr == 8'(i + 1)) begin
            bank_val = regs_q[i];
         end
      end
   end

   // Write-through so a same-cycle write is read back instead of the stale value.
   always_comb begin
      if (wr_hit && (wr_addr == rd_addr)) begin
         load_val = wr_data;
      end else begin
         load_val = rv(rd_addr, NUM_REGS, CHIP_ID, bank_val);
      end
   end

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RST_VAL;
         end
         wr_strobe_q <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
         end
         wr_strobe_q <= wr_strobe_d;
         addr_err_q  <= addr_err_d;
      end
   end

   always_comb begin
      reg_out = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         reg_out[DATA_W*i+DATA_W-1 -: DATA_W] = regs_q[i];
      end
   end

   assign wr_strobe = wr_strobe_q;
   assign addr_err  = addr_err_q;

   poci_shifter u_shifter (
      .sclk      (sclk),
      .rstn      (rstn),
      .byte_done (byte_done),
      .load_val  (load_val),
      .poci      (poci)
   );

endmodule

// File: tb/tb_reg_bank_poci.sv
// tb_reg_bank_poci: directed stimulus with a behavioural model compared every cycle,
// plus literal expectations for the documented test scenarios.
module tb_reg_bank_poci;

   localparam int unsigned NR = 16;

   logic          sclk = 1'b0;
   logic          rstn = 1'b0;
   logic          wr_valid = 1'b0;
   logic [7:0]    wr_addr = '0;
   logic [7:0]    wr_data = '0;
   logic          byte_done = 1'b0;
   logic [7:0]    rd_addr = '0;
   logic          poci;
   logic [NR*8-1:0] reg_out;
   logic          wr_strobe;
   logic          addr_err;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   reg_bank_poci #(
      .NUM_REGS (NR),
      .RST_VAL  (8'h00),
      .CHIP_ID  (8'hA5)
   ) dut (
      .sclk      (sclk),
      .rstn      (rstn),
      .wr_valid  (wr_valid),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .byte_done (byte_done),
      .rd_addr   (rd_addr),
      .poci      (poci),
      .reg_out   (reg_out),
      .wr_strobe (wr_strobe),
      .addr_err  (addr_err)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Readout: a byte loaded at a byte_done edge is shown bit (7-age) during the age-th
   // cycle after that edge, for age 0..7; otherwise poci is 0.
   logic [7:0] m_regs [1:NR];
   logic       m_strobe, m_err, m_active;
   logic [7:0] m_val;
   int         m_age;
   logic [7:0] m_load;
   bit         m_wr_ok;

   always_comb begin
      m_wr_ok = wr_valid && wr_addr >= 8'd1 && wr_addr <= 8'(NR);
      if (m_wr_ok && wr_addr == rd_addr) m_load = wr_data;
      else if (rd_addr == 8'd0)          m_load = 8'hA5;
      else if (rd_addr <= 8'(NR))        m_load = m_regs[int'(rd_addr)];
      else                               m_load = 8'h00;
   end

   always @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         for (int n = 1; n <= NR; n++) m_regs[n] <= 8'h00;
         m_strobe <= 1'b0;
         m_err    <= 1'b0;
         m_active <= 1'b0;
         m_val    <= 8'h00;
         m_age    <= 0;
      end else begin
         if (m_wr_ok) m_regs[int'(wr_addr)] <= wr_data;
         m_strobe <= m_wr_ok;
         if (wr_valid && wr_addr > 8'(NR)) m_err <= 1'b1;
         if (byte_done) begin
            m_val    <= m_load;
            m_age    <= 0;
            m_active <= 1'b1;
         end else if (m_active) begin
            m_age <= m_age + 1;
            if (m_age == 7) m_active <= 1'b0;
         end
      end
   end

   function automatic logic [NR*8-1:0] model_flat();
      logic [NR*8-1:0] f;
      f = '0;
      for (int n = 1; n <= NR; n++) f[8*n-1 -: 8] = m_regs[n];
      return f;
   endfunction

   function automatic logic model_poci();
      logic [7:0] v;
      v = m_val;
      if (!m_active) return 1'b0;
      return v[3'(7 - m_age)];
   endfunction

   always @(negedge sclk) begin
      if (chk_en && rstn) begin
         check("poci", 128'(poci), 128'(model_poci()));
         check("wr_strobe", 128'(wr_strobe), 128'(m_strobe));
         check("addr_err", 128'(addr_err), 128'(m_err));
         check("reg_out", 128'(reg_out), 128'(model_flat()));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic exp_strobe);
      @(negedge sclk);
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      @(negedge sclk);
      wr_valid = 1'b0;
      check("write_strobe_lit", 128'(wr_strobe), 128'(exp_strobe));
   endtask

   task automatic read_byte(input logic [7:0] a, output logic [7:0] v);
      @(negedge sclk);
      byte_done = 1'b1;
      rd_addr   = a;
      for (int i = 0; i < 8; i++) begin
         @(negedge sclk);
         byte_done = 1'b0;
         wr_valid  = 1'b0;
         v = {v[6:0], poci};
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0]  v;
      logic [15:0] bits;

      #12;
      @(negedge sclk);
      rstn = 1'b1;
      chk_en = 1'b1;

      // 1: reset state and chip id readout
      check("rst_poci", 128'(poci), 128'(0));
      check("rst_strobe", 128'(wr_strobe), 128'(0));
      check("rst_err", 128'(addr_err), 128'(0));
      check("rst_regs", 128'(reg_out), 128'(0));
      read_byte(8'd0, v);
      check("chip_id", 128'(v), 128'(8'hA5));
      @(negedge sclk);
      check("idle_after_byte", 128'(poci), 128'(0));

      // 2: write reg 3 and read it back
      do_write(8'd3, 8'h3C, 1'b1);
      check("reg3_slice", 128'(reg_out[23:16]), 128'(8'h3C));
      @(negedge sclk);
      check("strobe_one_cycle", 128'(wr_strobe), 128'(0));
      read_byte(8'd3, v);
      check("read_reg3", 128'(v), 128'(8'h3C));

      // 3: back-to-back bytes, byte_done every 8 cycles
      do_write(8'd1, 8'hFF, 1'b1);
      do_write(8'd2, 8'h81, 1'b1);
      bits = '0;
      for (int i = 0; i <= 16; i++) begin
         @(negedge sclk);
         if (i >= 1) bits = {bits[14:0], poci};
         byte_done = (i == 0 || i == 8);
         rd_addr   = (i < 8) ? 8'd1 : 8'd2;
      end
      check("stream_ff81", 128'(bits), 128'(16'hFF81));

      // 4: out-of-range write is dropped and flags a sticky error
      do_write(8'd17, 8'h55, 1'b0);
      check("err_set", 128'(addr_err), 128'(1));
      check("regs_untouched", 128'(reg_out[23:0]), 128'(24'h3C81FF));
      read_byte(8'd17, v);
      check("read_unmapped", 128'(v), 128'(8'h00));
      check("err_held", 128'(addr_err), 128'(1));

      // write to address 0 is ignored with no strobe
      do_write(8'd0, 8'h77, 1'b0);

      // 5: same-cycle write and load of the same address
      @(negedge sclk);
      wr_valid  = 1'b1;
      wr_addr   = 8'd5;
      wr_data   = 8'h9E;
      byte_done = 1'b1;
      rd_addr   = 8'd5;
      for (int i = 0; i < 8; i++) begin
         @(negedge sclk);
         wr_valid  = 1'b0;
         byte_done = 1'b0;
         v = {v[6:0], poci};
      end
      check("write_through", 128'(v), 128'(8'h9E));
      check("reg5_slice", 128'(reg_out[39:32]), 128'(8'h9E));

      // 6: reset in the middle of a byte
      do_write(8'd7, 8'hFF, 1'b1);
      @(negedge sclk);
      byte_done = 1'b1;
      rd_addr   = 8'd7;
      @(negedge sclk);
      byte_done = 1'b0;
      repeat (4) @(posedge sclk);
      #2;
      check("mid_byte_poci_high", 128'(poci), 128'(1));
      rstn = 1'b0;
      #1;
      check("reset_poci", 128'(poci), 128'(0));
      check("reset_err", 128'(addr_err), 128'(0));
      @(negedge sclk);
      @(negedge sclk);
      rstn = 1'b1;
      check("post_reset_regs", 128'(reg_out), 128'(0));
      repeat (4) begin
         @(negedge sclk);
         check("post_reset_idle", 128'(poci), 128'(0));
      end
      read_byte(8'd7, v);
      check("post_reset_read", 128'(v), 128'(8'h00));

      repeat (2) @(negedge sclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
